// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Optional build macro used by the design: SWITCH_DEBOUNCER_TOGGLE_EN.
package switch_pkg;

  localparam int unsigned CLK_HZ          = 100000000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int          SYNC_STAGES_DEF = 2;

  // Stable clocks needed for a debounce window of ms milliseconds.
  function automatic int unsigned cnt_max_f(input int unsigned clk_hz,
                                            input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int CNT_MAX_DEF = int'(cnt_max_f(CLK_HZ, DEBOUNCE_MS));

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: synchroniser, stability counter, level and strobes.
// With SWITCH_DEBOUNCER_TOGGLE_EN defined, adds an on/off latch driven by rise strobes.
module debounce_chan
  import switch_pkg::*;
#(
  parameter int CNT_MAX     = CNT_MAX_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CW          = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  ,
  output logic tog_o
`endif
);

  logic [SYNC_STAGES-2:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s_sync;

  // The level/counter registers form the final synchroniser stage, so the
  // decision looks at the value entering it; this gives SYNC_STAGES+CNT_MAX-1 latency.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = sw_i;
    s_sync    = sync_q[SYNC_STAGES-2];
    cnt_d     = cnt_q;
    db_d      = db_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (s_sync == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CNT_MAX - 1)) begin
      db_d   = s_sync;
      cnt_d  = '0;
      rise_d = s_sync;
      fall_d = ~s_sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  logic tog_q, tog_d;

  always_comb begin
    tog_d = tog_q ^ rise_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog_o = tog_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce_chan instances.
// Optional build macro: SWITCH_DEBOUNCER_TOGGLE_EN adds the sw_toggle output.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int CNT_MAX     = CNT_MAX_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] sw_toggle
`endif
);

  localparam int CW = $clog2(CNT_MAX + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .CNT_MAX     (CNT_MAX),
      .SYNC_STAGES (SYNC_STAGES),
      .CW          (CW)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sw_i   (sw[i]),
      .db_o   (sw_db[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
      ,
      .tog_o  (sw_toggle[i])
`endif
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bouncing inputs,
// all checked against a run-length reference model of the debounce rule.
module tb_switch_debouncer;

  localparam int WIDTH       = 2;
  localparam int CNT_MAX     = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  logic [WIDTH-1:0] sw_toggle;
`endif

  int total = 0;
  int bad   = 0;

  switch_debouncer #(
    .WIDTH       (WIDTH),
    .CNT_MAX     (CNT_MAX),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    .sw_toggle (sw_toggle)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a raw sample reaches the decision SYNC_STAGES-1 edges
  // later; a new level is accepted once CNT_MAX consecutive samples agree
  logic [WIDTH-1:0] pipe_q[$];
  logic [WIDTH-1:0] m_db, m_rise, m_fall, m_tog;
  logic [WIDTH-1:0] m_last;
  int               m_run[WIDTH];

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < SYNC_STAGES - 1; i++) pipe_q.push_back('0);
    m_db = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_last = '0;
    for (int c = 0; c < WIDTH; c++) m_run[c] = 0;
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] raw);
    logic [WIDTH-1:0] s;
    s = pipe_q.pop_front();
    pipe_q.push_back(raw);
    m_tog  = m_tog ^ m_rise;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (s[c] == m_last[c]) m_run[c] = m_run[c] + 1;
      else m_run[c] = 1;
      m_last[c] = s[c];
      if (s[c] != m_db[c] && m_run[c] >= CNT_MAX) begin
        m_db[c]   = s[c];
        m_rise[c] = s[c];
        m_fall[c] = ~s[c];
      end
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("db", 32'(sw_db), 32'(m_db));
    chk("rise", 32'(sw_rise), 32'(m_rise));
    chk("fall", 32'(sw_fall), 32'(m_fall));
    chk("excl", 32'(sw_rise & sw_fall), 32'd0);
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    chk("tog", 32'(sw_toggle), 32'(m_tog));
`endif
  endtask

  // driver: one clock edge, advance the model, sample just after the edge
  task automatic tick();
    @(posedge clk);
    model_edge(sw);
    #1;
    compare_model();
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    sw = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  // asynchronous reset pulse placed between two edges
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_db", 32'(sw_db), 32'd0);
    chk("rst_rise", 32'(sw_rise), 32'd0);
    chk("rst_fall", 32'(sw_fall), 32'd0);
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    chk("rst_tog", 32'(sw_toggle), 32'd0);
`endif
    model_reset();
    #1 rst = 1'b0;
  endtask

  int hold_cnt[WIDTH];

  initial begin
    rst = 1'b1;
    sw  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_db", 32'(sw_db), 32'd0);
    chk("reset_rise", 32'(sw_rise), 32'd0);
    chk("reset_fall", 32'(sw_fall), 32'd0);
    rst = 1'b0;

    // clean press: visible after edge 5
    sw = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("press_wait", 32'(sw_db), 32'd0);
    end
    tick();
    chk("press_db", 32'(sw_db), 32'h1);
    chk("press_rise", 32'(sw_rise), 32'h1);
    chk("press_fall", 32'(sw_fall), 32'h0);
    tick();
    chk("press_rise_off", 32'(sw_rise), 32'h0);

    // release
    sw = 2'b00;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("rel_wait", 32'(sw_db), 32'h1);
    end
    tick();
    chk("rel_db", 32'(sw_db), 32'h0);
    chk("rel_fall", 32'(sw_fall), 32'h1);
    tick();
    chk("rel_fall_off", 32'(sw_fall), 32'h0);

    // bounce on channel 0 is rejected
    for (int e = 0; e < 12; e++) begin
      sw = (e < 6) ? 2'(~e & 1) : 2'b00;
      tick();
      chk("bounce_db", 32'(sw_db), 32'h0);
      chk("bounce_strobe", 32'(sw_rise | sw_fall), 32'h0);
    end

    // simultaneous channels
    sw = 2'b11;
    repeat (4) tick();
    tick();
    chk("simul_db", 32'(sw_db), 32'h3);
    chk("simul_rise", 32'(sw_rise), 32'h3);
    hold(2'b00, 7);
    chk("simul_back", 32'(sw_db), 32'h0);

    // reset mid-count, then a full restart
    sw = 2'b10;
    repeat (3) tick();
    pulse_reset();
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("rstmid_wait", 32'(sw_db), 32'h0);
    end
    tick();
    chk("rstmid_db", 32'(sw_db), 32'h2);
    chk("rstmid_rise", 32'(sw_rise), 32'h2);
    hold(2'b00, 7);

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    hold(2'b01, 7);
    hold(2'b00, 7);
    chk("toggle_on", 32'(sw_toggle), 32'h1);
    hold(2'b01, 7);
    hold(2'b00, 7);
    chk("toggle_off", 32'(sw_toggle), 32'h0);
`endif

    // randomized bouncing with occasional async resets
    for (int c = 0; c < WIDTH; c++) hold_cnt[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (hold_cnt[c] == 0) begin
          sw[c]       = 1'($urandom_range(0, 1));
          hold_cnt[c] = int'($urandom_range(1, 8));
        end
        hold_cnt[c]--;
      end
      tick();
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-side conditioner for the board's slide switches and push buttons.
- Per channel: synchronises each raw pin to the fabric clock, rejects bounce with a stability counter, and emits a clean level plus one-cycle rise/fall strobes.
- Sits between the top-level sw pins and the logic that consumes them, including the led output logic. That logic then sees glitch-free, edge-qualified inputs instead of raw switch levels.

Parameters:
- WIDTH, 2, number of independent switch channels.
- CNT_MAX, 1000000, consecutive stable clocks required to accept a new level (10 ms at 100 MHz). Legal range 1..2^24-1.
- SYNC_STAGES, 2, flip-flops in the input synchroniser. Legal range 2..4.

Ports:
- clk  input  1  fabric clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  WIDTH  raw switch/button pins, asynchronous to clk.
- sw_db  output  WIDTH  debounced level per channel.
- sw_rise  output  WIDTH  one-cycle strobe when sw_db goes 0->1.
- sw_fall  output  WIDTH  one-cycle strobe when sw_db goes 1->0.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. All flops clear immediately on rst=1 and release on the first clk edge after rst falls.
- Reset values: sync chain, counters, sw_db, sw_rise and sw_fall are all 0.
- Synchroniser: per channel, SYNC_STAGES-deep flop chain. The last stage is s_sync.
- Counter width: $clog2(CNT_MAX+1) bits, unsigned.
- Per-channel rule, evaluated every edge:
  - If s_sync == sw_db: counter <= 0 and no strobe.
  - Else if counter == CNT_MAX-1: sw_db <= s_sync, counter <= 0, and the matching strobe is registered high for exactly this one cycle.
  - Else: counter <= counter+1.
- Strobe alignment: sw_rise/sw_fall are registered and assert in the same cycle sw_db first shows its new value. They deassert the next cycle.
- Latency: the raw level sampled at edge 1 is visible on sw_db after edge SYNC_STAGES+CNT_MAX-1, provided it is held throughout.
- Glitch rejection: any return of s_sync to the current sw_db before the count completes clears the counter. There is no partial credit and the counter never saturates.
- Power-up with a switch held high: sw_db rises after full latency from reset release, with a sw_rise strobe (baseline is 0).
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.
- CNT_MAX=1 boundary: the new level is accepted on the first edge s_sync differs.
- Reset mid-count: the counter and any pending level are discarded and the channel restarts from 0.
- sw_rise and sw_fall are never high together on the same channel.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_TOGGLE_EN.
- When defined:
  - Extra output port sw_toggle (WIDTH bits, reset 0).
  - Each bit inverts on the cycle after its sw_rise strobe, turning a push button into an on/off latch.
- When undefined: the port and its flops do not exist. All other behaviour is identical.

Decomposition:
- Shared package switch_pkg holds:
  - default constants CLK_HZ=100000000 and DEBOUNCE_MS=10;
  - function cnt_max_f(clk_hz, ms) for CNT_MAX;
  - localparam for default SYNC_STAGES.
- Natural sub-module debounce_chan: one channel (sync chain, counter, level, strobes, optional toggle). The top instantiates it WIDTH times in a generate loop.

Test Plan (bench uses CNT_MAX=4, SYNC_STAGES=2, WIDTH=2, sw changes just after an edge):
- Clean press: sw=2'b01 held from edge 1 -> sw_db=2'b01 after edge 5; sw_rise=2'b01 for exactly that one cycle; sw_fall stays 0.
- Bounce: sw[0] toggles 1,0,1,0 each cycle for 6 cycles then settles 0 -> sw_db[0] never leaves 0, no strobes.
- Release: from sw_db=2'b01, sw=2'b00 held -> sw_db=2'b00 after 5 edges; sw_fall=2'b01 for one cycle.
- Simultaneous channels: sw goes 2'b00->2'b11 at one edge -> both sw_db bits and both sw_rise bits change in the same cycle.
- Reset mid-count: sw=2'b10 held, rst pulsed high between edges 3 and 4 -> outputs 0 immediately; after release sw_db[1] rises a full 5 edges later.
- Toggle (macro defined): two separate debounced presses on sw[0] -> sw_toggle[0] goes 0->1 after the first press, 1->0 after the second.
